branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised branch target buffer with per-entry saturating direction counters, the successor to the pipeline's resolve-only branch unit. It sits beside fetch and predicts the next PC every cycle from the fetch PC. It is trained by branch/jump outcomes resolved in execute. It also reports mispredictions and the corrected PC, and keeps saturating statistics counters.

## Interface
Parameters:
- ENTRIES, 16, number of direct-mapped entries; power of two, 2..256; IDX_BITS = log2(ENTRIES)
- CTR_BITS, 2, direction counter width, 1..4; THRESH = 2^(CTR_BITS-1)

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- en  in  1  pipeline advance; 0 = hold all state (stall)
- flush  in  1  synchronous invalidate of all entries (qualified by en)
- fetch_pc  in  32  current fetch address, word aligned
- pred_taken  out  1  prediction for fetch_pc
- pred_target  out  32  predicted next PC
- resolve_valid  in  1  a control-transfer instruction resolved this cycle
- resolve_pc  in  32  its address
- resolve_taken  in  1  actual direction
- resolve_target  in  32  actual target
- resolve_pred_taken  in  1  prediction carried down the pipe with it
- resolve_pred_target  in  32  predicted next PC carried down the pipe
- mispredict  out  1  redirect required
- correct_pc  out  32  redirect address
- stat_resolved  out  32  resolved-branch count
- stat_mispredict  out  32  mispredict count

## Operation
- Address split: index = pc[IDX_BITS+1:2]; tag = pc[31:IDX_BITS+2].
- Entry fields: valid, tag, target[31:2], ctr[CTR_BITS-1:0].
- Lookup (combinational from fetch_pc and current state):
  - hit = valid && tag match at fetch index.
  - pred_taken = hit && ctr[CTR_BITS-1].
  - pred_target = pred_taken ? {target,2'b00} : fetch_pc+4, modulo 2^32.
- Resolve outputs (combinational, independent of en):
  - mispredict = resolve_valid && (resolve_taken != resolve_pred_taken || (resolve_taken && resolve_target != resolve_pred_target)).
  - correct_pc = resolve_taken ? resolve_target : resolve_pc+4.
  - When resolve_valid=0: mispredict=0; correct_pc is still driven by the formula.
- Update on the clock edge when en && resolve_valid && !flush:
  - Resolve hit, taken: ctr saturating +1 (max 2^CTR_BITS-1); target rewritten.
  - Resolve hit, not taken: ctr saturating -1 (min 0); target unchanged.
  - Resolve miss, taken: allocate/replace; valid=1, tag, target, ctr=THRESH (weakly taken).
  - Resolve miss, not taken: no change.
- Flush: when en && flush, every valid bit clears; tags, targets and ctr values are don't-care afterwards.
- Statistics: when en && resolve_valid, stat_resolved +1, and stat_mispredict +1 if mispredict. Both saturate at 0xFFFFFFFF. Flush does not inhibit or clear them.

## Timing
- Reset (async, nRST=0): all valid=0, ctr=0, targets=0, stats=0. Outputs during reset: pred_taken=0, pred_target=fetch_pc+4, stats 0.
- Prediction latency: 0 cycles (combinational). Training becomes visible to lookup on the cycle after the update edge.
- No write-to-read bypass: a same-cycle lookup at the index being updated returns the old state.
- en=0: no table or stat change, even with resolve_valid or flush asserted. Combinational outputs still evaluate.
- flush and resolve_valid in the same enabled cycle: flush wins, no allocation, stats still count.
- CTR_BITS=1: THRESH=1; an allocated entry predicts taken; one not-taken resolve clears it to 0.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.

## Test plan
Defaults ENTRIES=16, CTR_BITS=2.
- Cold start: reset, fetch_pc=0x100 -> pred_taken=0, pred_target=0x104; fetch_pc=0xFFFFFFFC -> pred_target=0x00000000.
- Allocate: resolve pc=0x100, taken, target=0x80, pred_taken=0 -> mispredict=1, correct_pc=0x80. Next cycle fetch 0x100 -> pred_taken=1, pred_target=0x80, stat_resolved=1, stat_mispredict=1.
- Counter saturation at pc 0x100:
  - Two more taken resolves -> ctr 3.
  - Three not-taken -> ctr 2,1,0; pred_taken=0 from ctr 1 onward.
  - A fourth not-taken keeps ctr 0.
  - Each not-taken resolve with pred_taken=0 -> mispredict=0, correct_pc=0x104.
- Alias/replace: with 0x100 trained taken, fetch 0x140 (same index 0, different tag) -> pred_taken=0. A taken resolve at 0x140 to 0x200 makes 0x140 predict 0x200 and 0x100 miss.
- Wrong target: resolve taken, target 0x300, pred_taken=1, pred_target=0x80 -> mispredict=1, correct_pc=0x300; the entry's target becomes 0x300.
- Stall/flush:
  - en=0 with resolve_valid=1, flush=1 -> table and stats unchanged.
  - en=1 with flush=1 and a taken resolve at 0x180 -> all entries miss next cycle, 0x180 not allocated, stat_resolved incremented.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Predicts the next fetch PC combinationally. Training and statistics come from execute-stage resolves.
module branch_predictor #(
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        resolve_valid,
    input  logic [31:0] resolve_pc,
    input  logic        resolve_taken,
    input  logic [31:0] resolve_target,
    input  logic        resolve_pred_taken,
    input  logic [31:0] resolve_pred_target,
    output logic        mispredict,
    output logic [31:0] correct_pc,
    output logic [31:0] stat_resolved,
    output logic [31:0] stat_mispredict
);
    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS = 30 - IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] THRESH  = CTR_ONE << (CTR_BITS - 1);

    logic [ENTRIES-1:0]  valid;
    logic [TAG_BITS-1:0] tags    [ENTRIES];
    logic [29:0]         targets [ENTRIES];
    logic [CTR_BITS-1:0] ctrs    [ENTRIES];

    logic [IDX_BITS-1:0] f_idx;
    logic [IDX_BITS-1:0] r_idx;
    logic [TAG_BITS-1:0] f_tag;
    logic [TAG_BITS-1:0] r_tag;
    logic                f_hit;
    logic                r_hit;

    assign f_idx = fetch_pc[IDX_BITS+1:2];
    assign f_tag = fetch_pc[31:IDX_BITS+2];
    assign r_idx = resolve_pc[IDX_BITS+1:2];
    assign r_tag = resolve_pc[31:IDX_BITS+2];

    // Lookup reads only registered state, so a same-cycle update is never bypassed.
    assign f_hit       = valid[f_idx] && (tags[f_idx] == f_tag);
    assign r_hit       = valid[r_idx] && (tags[r_idx] == r_tag);
    assign pred_taken  = f_hit && ctrs[f_idx][CTR_BITS-1];
    assign pred_target = pred_taken ? {targets[f_idx], 2'b00} : fetch_pc + 32'd4;

    assign mispredict = resolve_valid &&
                        ((resolve_taken != resolve_pred_taken) ||
                         (resolve_taken && (resolve_target != resolve_pred_target)));
    assign correct_pc = resolve_taken ? resolve_target : resolve_pc + 32'd4;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= '0;
            // NOTE: the table is reset entry by entry because a defined post-reset target/counter state is required; this costs a reset on every storage bit.
            for (int i = 0; i < ENTRIES; i++) begin
                tags[i]    <= '0;
                targets[i] <= '0;
                ctrs[i]    <= '0;
            end
            stat_resolved   <= '0;
            stat_mispredict <= '0;
        end else if (en) begin
            if (flush) begin
                valid <= '0;
            end else if (resolve_valid) begin
                if (r_hit) begin
                    if (resolve_taken) begin
                        if (ctrs[r_idx] != CTR_MAX) ctrs[r_idx] <= ctrs[r_idx] + CTR_ONE;
                        targets[r_idx] <= resolve_target[31:2];
                    end else if (ctrs[r_idx] != '0) begin
                        ctrs[r_idx] <= ctrs[r_idx] - CTR_ONE;
                    end
                end else if (resolve_taken) begin
                    valid[r_idx]   <= 1'b1;
                    tags[r_idx]    <= r_tag;
                    targets[r_idx] <= resolve_target[31:2];
                    ctrs[r_idx]    <= THRESH;
                end
            end

            // Statistics keep counting through a flush.
            if (resolve_valid) begin
                if (stat_resolved != '1) stat_resolved <= stat_resolved + 32'd1;
                if (mispredict && (stat_mispredict != '1)) stat_mispredict <= stat_mispredict + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: the driver queues hand-computed expectations,
// and a negedge monitor pops each expectation and compares it against the DUT outputs.
module tb_branch_predictor;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        en = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        resolve_valid = 1'b0;
    logic [31:0] resolve_pc = '0;
    logic        resolve_taken = 1'b0;
    logic [31:0] resolve_target = '0;
    logic        resolve_pred_taken = 1'b0;
    logic [31:0] resolve_pred_target = '0;
    logic        mispredict;
    logic [31:0] correct_pc;
    logic [31:0] stat_resolved;
    logic [31:0] stat_mispredict;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    branch_predictor #(.ENTRIES(16), .CTR_BITS(2)) dut (
        .CLK                 (CLK),
        .nRST                (nRST),
        .en                  (en),
        .flush               (flush),
        .fetch_pc            (fetch_pc),
        .pred_taken          (pred_taken),
        .pred_target         (pred_target),
        .resolve_valid       (resolve_valid),
        .resolve_pc          (resolve_pc),
        .resolve_taken       (resolve_taken),
        .resolve_target      (resolve_target),
        .resolve_pred_taken  (resolve_pred_taken),
        .resolve_pred_target (resolve_pred_target),
        .mispredict          (mispredict),
        .correct_pc          (correct_pc),
        .stat_resolved       (stat_resolved),
        .stat_mispredict     (stat_mispredict)
    );

    typedef struct {
        string       tag;
        logic        pt;
        logic [31:0] ptgt;
        logic        mp;
        logic [31:0] cpc;
        logic [31:0] sr;
        logic [31:0] sm;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, req);
        end
    endtask

    // Monitor: one queued expectation per driven cycle, compared mid-cycle.
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, ".pred_taken"},      32'(pred_taken), 32'(e.pt));
            check({e.tag, ".pred_target"},     pred_target,     e.ptgt);
            check({e.tag, ".mispredict"},      32'(mispredict), 32'(e.mp));
            check({e.tag, ".correct_pc"},      correct_pc,      e.cpc);
            check({e.tag, ".stat_resolved"},   stat_resolved,   e.sr);
            check({e.tag, ".stat_mispredict"}, stat_mispredict, e.sm);
        end
    end

    task automatic step(input string tag, input logic s_en, input logic s_fl,
                        input logic [31:0] fpc, input logic rv, input logic [31:0] rpc,
                        input logic rt, input logic [31:0] rtgt,
                        input logic rpt, input logic [31:0] rptgt,
                        input logic e_pt, input logic [31:0] e_ptgt,
                        input logic e_mp, input logic [31:0] e_cpc,
                        input logic [31:0] e_sr, input logic [31:0] e_sm);
        exp_t e;
        @(posedge CLK);
        #1;
        en                  = s_en;
        flush               = s_fl;
        fetch_pc            = fpc;
        resolve_valid       = rv;
        resolve_pc          = rpc;
        resolve_taken       = rt;
        resolve_target      = rtgt;
        resolve_pred_taken  = rpt;
        resolve_pred_target = rptgt;
        e.tag  = tag;
        e.pt   = e_pt;
        e.ptgt = e_ptgt;
        e.mp   = e_mp;
        e.cpc  = e_cpc;
        e.sr   = e_sr;
        e.sm   = e_sm;
        sb.push_back(e);
    endtask

    // Lookup-only cycle: no resolve, so correct_pc = 0 + 4.
    task automatic idle(input string tag, input logic [31:0] fpc, input logic e_pt,
                        input logic [31:0] e_ptgt, input logic [31:0] e_sr, input logic [31:0] e_sm);
        step(tag, 1'b1, 1'b0, fpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
             e_pt, e_ptgt, 1'b0, 32'h4, e_sr, e_sm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Outputs while held in reset.
        idle("rst_0x100", 32'h100, 1'b0, 32'h104, 0, 0);
        idle("rst_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0, 0, 0);
        @(posedge CLK);
        #1 nRST = 1'b1;

        idle("cold", 32'h100, 1'b0, 32'h104, 0, 0);
        // Allocate 0x100 -> 0x80; no bypass in the same cycle.
        step("alloc", 1, 0, 32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104,
             0, 32'h104, 1, 32'h80, 0, 0);
        idle("alloc_vis", 32'h100, 1'b1, 32'h80, 1, 1);
        // Two more taken resolves: ctr 2 -> 3 -> 3.
        step("tk1", 1, 0, 32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80,
             1, 32'h80, 0, 32'h80, 1, 1);
        step("tk2", 1, 0, 32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80,
             1, 32'h80, 0, 32'h80, 2, 1);
        // Not-taken: ctr 3 -> 2 -> 1 -> 0 -> 0.
        step("nt1", 1, 0, 32'h100, 1, 32'h100, 0, 32'h80, 1, 32'h80,
             1, 32'h80, 1, 32'h104, 3, 1);
        step("nt2", 1, 0, 32'h100, 1, 32'h100, 0, 32'h80, 1, 32'h80,
             1, 32'h80, 1, 32'h104, 4, 2);
        step("nt3", 1, 0, 32'h100, 1, 32'h100, 0, 32'h80, 0, 32'h104,
             0, 32'h104, 0, 32'h104, 5, 3);
        step("nt4", 1, 0, 32'h100, 1, 32'h100, 0, 32'h80, 0, 32'h104,
             0, 32'h104, 0, 32'h104, 6, 3);
        // Counter held at 0: two taken resolves bring it to 1 then 2.
        step("rise1", 1, 0, 32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104,
             0, 32'h104, 1, 32'h80, 7, 3);
        step("rise2", 1, 0, 32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104,
             0, 32'h104, 1, 32'h80, 8, 4);
        idle("trained", 32'h100, 1'b1, 32'h80, 9, 5);

        // Alias at index 0 with a different tag replaces the entry.
        step("alias", 1, 0, 32'h140, 1, 32'h140, 1, 32'h200, 0, 32'h144,
             0, 32'h144, 1, 32'h200, 9, 5);
        idle("alias_hit", 32'h140, 1'b1, 32'h200, 10, 6);
        idle("alias_evict", 32'h100, 1'b0, 32'h104, 10, 6);

        // Right direction, wrong target.
        step("wrong_tgt", 1, 0, 32'h140, 1, 32'h140, 1, 32'h300, 1, 32'h200,
             1, 32'h200, 1, 32'h300, 10, 6);
        idle("new_tgt", 32'h140, 1'b1, 32'h300, 11, 7);

        // Second entry at index 1.
        step("alloc_i1", 1, 0, 32'h104, 1, 32'h104, 1, 32'h400, 0, 32'h108,
             0, 32'h108, 1, 32'h400, 11, 7);
        idle("i1_hit", 32'h104, 1'b1, 32'h400, 12, 8);

        // Stall with flush and resolve asserted: nothing changes.
        step("stall", 0, 1, 32'h140, 1, 32'h180, 1, 32'h500, 0, 32'h184,
             1, 32'h300, 1, 32'h500, 12, 8);
        idle("stall_kept", 32'h104, 1'b1, 32'h400, 12, 8);

        // Flush beats the resolve; statistics still count.
        step("flush", 1, 1, 32'h140, 1, 32'h180, 1, 32'h500, 0, 32'h184,
             1, 32'h300, 1, 32'h500, 12, 8);
        idle("fl_i0", 32'h140, 1'b0, 32'h144, 13, 9);
        idle("fl_i1", 32'h104, 1'b0, 32'h108, 13, 9);
        idle("fl_noalloc", 32'h180, 1'b0, 32'h184, 13, 9);

        // Idle resolve bus: mispredict masked, correct_pc still formed, no count.
        step("rv0", 1, 0, 32'h180, 0, 32'h200, 1, 32'h600, 0, 32'h204,
             0, 32'h184, 0, 32'h600, 13, 9);
        step("realloc", 1, 0, 32'h180, 1, 32'h180, 1, 32'h700, 0, 32'h184,
             0, 32'h184, 0 | 1, 32'h700, 13, 9);
        idle("realloc_hit", 32'h180, 1'b1, 32'h700, 14, 10);

        // Asynchronous reset in mid-cycle, with no clock edge before the check.
        idle("async_rst", 32'h180, 1'b0, 32'h184, 0, 0);
        #1 nRST = 1'b0;
        @(posedge CLK);
        #1 nRST = 1'b1;
        idle("post_rst", 32'h180, 1'b0, 32'h184, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge CLK);
        #1;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d expected=0 pending", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
